// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array sequencer and its skew buffers.
package systolic_pkg;

   localparam int SYS_N   = 4;
   localparam int OP_W    = 8;
   localparam int ACC_W   = 32;
   localparam int RUN_LEN = 3 * SYS_N - 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   // Number of RUN cycles needed for the last operand pair to reach PE[N-1][N-1].
   function automatic int run_len(input int n);
      return 3 * n - 2;
   endfunction

   // Counter width that holds 0 .. 3N-2 without wrapping.
   function automatic int cnt_width(input int n);
      return $clog2(3 * n - 1);
   endfunction

endpackage

// File: rtl/systolic_skew_buffer.sv
// N skewed lanes: parallel load of a diagonally offset operand matrix, then
// shift toward slot 0 one slot per enabled cycle, zero-filling the far end.
module systolic_skew_buffer
   import systolic_pkg::*;
#(
   parameter int N      = SYS_N,
   parameter bit IS_COL = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load,
   input  logic                              shift,
   input  logic [N-1:0][N-1:0][OP_W-1:0]     mat,
   output logic [N-1:0][2*N-2:0][OP_W-1:0]   lanes
);

   logic [N-1:0][2*N-2:0][OP_W-1:0] load_val;
   logic [N-1:0][2*N-2:0][OP_W-1:0] shifted;

   // Lane l slot s carries the operand whose index along the lane equals s-l;
   // rows walk along columns of A, cols walk along rows of B.
   for (genvar l = 0; l < N; l++) begin : g_lane
      for (genvar s = 0; s < 2*N-1; s++) begin : g_slot
         if (s >= l && s - l < N) begin : g_data
            if (IS_COL) begin : g_col
               assign load_val[l][s] = mat[s-l][l];
            end else begin : g_row
               assign load_val[l][s] = mat[l][s-l];
            end
         end else begin : g_zero
            assign load_val[l][s] = '0;
         end
      end
      assign shifted[l] = {OP_W'(0), lanes[l][2*N-2:1]};
   end

   // Load on acceptance, shift while the array runs, otherwise hold all lanes at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes <= '0;
      end else if (load) begin
         lanes <= load_val;
      end else if (shift) begin
         lanes <= shifted;
      end else begin
         lanes <= '0;
      end
   end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for an N x N output-stationary systolic array: feeds skewed operands,
// runs the array for 3N-2 cycles, captures the accumulators and hands them off.
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int N = SYS_N
) (
   input  logic                              i_clk,
   input  logic                              i_arst,
   input  logic                              i_start,
   input  logic [N-1:0][N-1:0][OP_W-1:0]     i_a,
   input  logic [N-1:0][N-1:0][OP_W-1:0]     i_b,
   output logic                              o_ready,
   output logic [N-1:0][2*N-2:0][OP_W-1:0]   o_row,
   output logic [N-1:0][2*N-2:0][OP_W-1:0]   o_col,
   output logic                              o_doProcess,
   input  logic [N-1:0][N-1:0][ACC_W-1:0]    i_c,
   output logic [N-1:0][N-1:0][ACC_W-1:0]    o_result,
   output logic                              o_valid,
   input  logic                              i_ready
);

   localparam int               CNT_W    = cnt_width(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(run_len(N) - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             run_last;

   // State register; reset always lands in IDLE so an interrupted run is abandoned.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs; a start outside IDLE is simply not looked at.
   always_comb begin
      state_next  = state;
      o_ready     = 1'b0;
      o_doProcess = 1'b0;
      o_valid     = 1'b0;
      accept      = 1'b0;
      run_last    = 1'b0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            o_doProcess = 1'b1;
            if (cnt == CNT_LAST) begin
               run_last   = 1'b1;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = DONE;
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // RUN cycle counter: zero on entry, stops at the last count so it never wraps.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         cnt <= '0;
      end else if (state == RUN && !run_last) begin
         cnt <= cnt + 1'b1;
      end else begin
         cnt <= '0;
      end
   end

   // Grab the accumulators at the end of DRAIN; the value persists until the next run.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         o_result <= '0;
      end else if (state == DRAIN) begin
         o_result <= i_c;
      end
   end

   systolic_skew_buffer #(
      .N      (N),
      .IS_COL (1'b0)
   ) u_row_buf (
      .clk   (i_clk),
      .rst   (i_arst),
      .load  (accept),
      .shift (o_doProcess),
      .mat   (i_a),
      .lanes (o_row)
   );

   systolic_skew_buffer #(
      .N      (N),
      .IS_COL (1'b1)
   ) u_col_buf (
      .clk   (i_clk),
      .rst   (i_arst),
      .load  (accept),
      .shift (o_doProcess),
      .mat   (i_b),
      .lanes (o_col)
   );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer with a behavioural N x N array driving i_c and a
// scoreboard queue of hand-computed products checked by a negedge monitor.
module tb_systolic_sequencer;
   import systolic_pkg::*;

   localparam int N = 4;

   typedef logic [N-1:0][N-1:0][7:0]  op_mat_t;
   typedef logic [N-1:0][N-1:0][31:0] acc_mat_t;

   logic                         i_clk = 1'b0;
   logic                         i_arst;
   logic                         i_start;
   logic                         i_ready;
   op_mat_t                      i_a;
   op_mat_t                      i_b;
   logic                         o_ready;
   logic [N-1:0][2*N-2:0][7:0]   o_row;
   logic [N-1:0][2*N-2:0][7:0]   o_col;
   logic                         o_doProcess;
   acc_mat_t                     i_c;
   acc_mat_t                     o_result;
   logic                         o_valid;

   int       pass_cnt = 0;
   int       check_cnt = 0;
   acc_mat_t exp_q[$];

   logic [31:0] pe_acc  [N][N];
   logic [7:0]  pe_a    [N][N];
   logic [7:0]  pe_b    [N][N];
   logic [7:0]  pe_a_in [N][N];
   logic [7:0]  pe_b_in [N][N];

   systolic_sequencer #(.N(N)) dut (
      .i_clk       (i_clk),
      .i_arst      (i_arst),
      .i_start     (i_start),
      .i_a         (i_a),
      .i_b         (i_b),
      .o_ready     (o_ready),
      .o_row       (o_row),
      .o_col       (o_col),
      .o_doProcess (o_doProcess),
      .i_c         (i_c),
      .o_result    (o_result),
      .o_valid     (o_valid),
      .i_ready     (i_ready)
   );

   always #5 i_clk = ~i_clk;

   // Operands enter PE[i][0] from row lanes and PE[0][j] from col lanes, then hop one PE per cycle.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            pe_a_in[i][j] = (j == 0) ? o_row[i][0] : pe_a[i][(j == 0) ? 0 : j-1];
            pe_b_in[i][j] = (i == 0) ? o_col[j][0] : pe_b[(i == 0) ? 0 : i-1][j];
            i_c[i][j]     = pe_acc[i][j];
         end
      end
   end

   // Array behaviour: multiply-accumulate while enabled, clear everything on any edge without enable.
   always @(posedge i_clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!o_doProcess) begin
               pe_acc[i][j] <= '0;
               pe_a[i][j]   <= '0;
               pe_b[i][j]   <= '0;
            end else begin
               pe_acc[i][j] <= pe_acc[i][j] + 32'(pe_a_in[i][j]) * 32'(pe_b_in[i][j]);
               pe_a[i][j]   <= pe_a_in[i][j];
               pe_b[i][j]   <= pe_b_in[i][j];
            end
         end
      end
   end

   function automatic op_mat_t op_fill(input logic [7:0] v);
      op_mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = v;
      return m;
   endfunction

   function automatic op_mat_t op_diag(input logic [7:0] v);
      op_mat_t m;
      m = '0;
      for (int i = 0; i < N; i++) m[i][i] = v;
      return m;
   endfunction

   function automatic op_mat_t op_ramp(input int k, input int base);
      op_mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = 8'(k * r + c + base);
      return m;
   endfunction

   function automatic acc_mat_t acc_fill(input int v);
      acc_mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = 32'(v);
      return m;
   endfunction

   function automatic acc_mat_t acc_ramp(input int k, input int mult, input int base);
      acc_mat_t m;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            m[r][c] = 32'(mult * (k * r + c + base));
      return m;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic checkMatrix(input string name, input acc_mat_t actual, input acc_mat_t expected);
      int bad_r = -1;
      int bad_c = -1;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (actual[r][c] !== expected[r][c] && bad_r < 0) begin
               bad_r = r;
               bad_c = c;
            end
      check_cnt++;
      if (bad_r < 0) pass_cnt++;
      else $display("[TB] FAIL %s: element [%0d][%0d] got %0d, expected %0d",
                    name, bad_r, bad_c, actual[bad_r][bad_c], expected[bad_r][bad_c]);
   endtask

   task automatic monitorPop();
      acc_mat_t expected;
      if (exp_q.size() == 0) begin
         checkOutput("unexpected_result", 32'(o_valid), 32'd0);
      end else begin
         expected = exp_q.pop_front();
         checkMatrix("result", o_result, expected);
      end
   endtask

   // Scoreboard monitor: every handshake consumes one queued expectation.
   always @(negedge i_clk) begin
      if (!i_arst && o_valid && i_ready) monitorPop();
   end

   task automatic applyStimulus(input op_mat_t a, input op_mat_t b, input acc_mat_t expected, input bit hold);
      int guard = 0;
      while (!o_ready && guard < 100) begin
         @(negedge i_clk);
         guard++;
      end
      if (!o_ready) checkOutput("ready_timeout", 32'(o_ready), 32'd1);
      @(posedge i_clk);
      #2;
      i_a     = a;
      i_b     = b;
      i_start = 1'b1;
      exp_q.push_back(expected);
      @(posedge i_clk);
      #2;
      if (!hold) i_start = 1'b0;
   endtask

   task automatic waitDrain();
      int guard = 0;
      while (!(o_ready && exp_q.size() == 0) && guard < 200) begin
         @(negedge i_clk);
         guard++;
      end
      checkOutput("drain_done", 32'(o_ready && exp_q.size() == 0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int first_valid;
      int dp;
      int rdy_low;
      int rise2;
      int v2;

      i_arst  = 1'b1;
      i_start = 1'b0;
      i_ready = 1'b1;
      i_a     = '0;
      i_b     = '0;
      #11;
      checkOutput("reset_ready", 32'(o_ready), 32'd1);
      checkOutput("reset_valid", 32'(o_valid), 32'd0);
      checkOutput("reset_doprocess", 32'(o_doProcess), 32'd0);
      checkMatrix("reset_result", o_result, acc_fill(0));
      #1;
      i_arst = 1'b0;

      $display("[TB] identity x ramp, latency and enable length");
      applyStimulus(op_diag(1), op_ramp(4, 1), acc_ramp(4, 1, 1), 1'b0);
      first_valid = 0;
      dp = 0;
      for (int k = 1; k <= 40 && first_valid == 0; k++) begin
         @(negedge i_clk);
         if (k == 1) begin
            checkOutput("row0_slot0", 32'(o_row[0][0]), 32'd1);
            checkOutput("row3_slot6", 32'(o_row[3][6]), 32'd1);
            checkOutput("col1_slot1", 32'(o_col[1][1]), 32'd2);
            checkOutput("col2_slot5", 32'(o_col[2][5]), 32'd15);
         end
         if (k == 11) checkOutput("lanes_zero_drain", 32'(o_row == '0 && o_col == '0), 32'd1);
         if (o_doProcess) dp++;
         if (o_valid) first_valid = k;
      end
      checkOutput("valid_latency", 32'(first_valid), 32'd12);
      checkOutput("doprocess_cycles", 32'(dp), 32'd10);
      waitDrain();

      $display("[TB] all 255 operands");
      applyStimulus(op_fill(255), op_fill(255), acc_fill(260100), 1'b0);
      waitDrain();

      $display("[TB] start pulse during RUN is ignored");
      applyStimulus(op_diag(2), op_ramp(1, 0), acc_ramp(1, 2, 0), 1'b0);
      rdy_low = 0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge i_clk);
         if (!o_ready) rdy_low++;
         if (k == 3) begin
            i_start = 1'b1;
            i_a     = op_fill(255);
            i_b     = op_fill(7);
         end
         if (k == 4) i_start = 1'b0;
      end
      checkOutput("ready_low_run", 32'(rdy_low), 32'd11);
      waitDrain();

      $display("[TB] consumer stalls for several cycles");
      i_ready = 1'b0;
      applyStimulus(op_fill(1), op_diag(1), acc_fill(1), 1'b0);
      first_valid = 0;
      for (int k = 1; k <= 40 && first_valid == 0; k++) begin
         @(negedge i_clk);
         if (o_valid) first_valid = k;
      end
      checkOutput("stall_valid_latency", 32'(first_valid), 32'd12);
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         checkOutput("stall_valid_hold", 32'(o_valid), 32'd1);
         checkMatrix("stall_result_hold", o_result, acc_fill(1));
      end
      @(posedge i_clk);
      #2;
      i_ready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      checkOutput("after_handshake_ready", 32'(o_ready), 32'd1);
      checkOutput("after_handshake_valid", 32'(o_valid), 32'd0);
      checkMatrix("result_retained", o_result, acc_fill(1));

      $display("[TB] reset in the middle of RUN");
      applyStimulus(op_diag(1), op_ramp(4, 1), acc_ramp(4, 1, 1), 1'b0);
      for (int k = 1; k <= 5; k++) @(negedge i_clk);
      checkOutput("pre_reset_doprocess", 32'(o_doProcess), 32'd1);
      i_arst = 1'b1;
      #1;
      checkOutput("arst_doprocess", 32'(o_doProcess), 32'd0);
      checkOutput("arst_valid", 32'(o_valid), 32'd0);
      checkOutput("arst_lanes_zero", 32'(o_row == '0 && o_col == '0), 32'd1);
      checkOutput("arst_ready", 32'(o_ready), 32'd1);
      checkMatrix("arst_result", o_result, acc_fill(0));
      void'(exp_q.pop_back());
      #3;
      i_arst = 1'b0;
      applyStimulus(op_fill(1), op_fill(2), acc_fill(8), 1'b0);
      waitDrain();

      $display("[TB] back-to-back with start held high");
      applyStimulus(op_diag(1), op_ramp(4, 1), acc_ramp(4, 1, 1), 1'b1);
      i_a = op_fill(255);
      i_b = op_fill(255);
      exp_q.push_back(acc_fill(260100));
      rise2 = 0;
      v2 = 0;
      for (int k = 1; k <= 60 && v2 == 0; k++) begin
         @(negedge i_clk);
         if (k == 10) checkOutput("b2b_last_run_cycle", 32'(o_doProcess), 32'd1);
         if (k == 11) checkOutput("b2b_drain_low", 32'(o_doProcess), 32'd0);
         if (k == 13) checkOutput("b2b_idle_ready", 32'(o_ready), 32'd1);
         if (k > 11 && o_doProcess && rise2 == 0) begin
            rise2 = k;
            i_start = 1'b0;
         end
         if (k > 12 && o_valid) v2 = k;
      end
      i_start = 1'b0;
      checkOutput("b2b_second_run_start", 32'(rise2), 32'd14);
      checkOutput("b2b_second_valid", 32'(v2), 32'd25);
      waitDrain();

      checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, meaning the array dimension (N x N PEs, 8-bit operands, 32-bit accumulators).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_arst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_start, input, 1, request to multiply i_a by i_b; sampled only in IDLE.
REQ-005 SHALL have ports i_a and i_b, input, [N-1:0][N-1:0][7:0], unsigned operand matrices [row][col], sampled with an accepted i_start.
REQ-006 SHALL have port o_ready, output, 1, high exactly while in IDLE.
REQ-007 SHALL have ports o_row and o_col, output, [N-1:0][(2N)-2:0][7:0], skewed feeds to the array; the array consumes slot 0 of each lane.
REQ-008 SHALL have port o_doProcess, output, 1, array enable; the array accumulates while high and clears its accumulators on any edge where it is low.
REQ-009 SHALL have port i_c, input, [N-1:0][N-1:0][31:0], array accumulator outputs.
REQ-010 SHALL have ports o_result, output, [N-1:0][N-1:0][31:0], and o_valid, output, 1, captured product and its valid flag.
REQ-011 SHALL have port i_ready, input, 1, consumer acceptance of o_result.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE -> RUN on i_start high; i_start in any other state SHALL be ignored, not queued.
REQ-014 On acceptance, row lane i slot s SHALL load i_a[i][s-i] when 0 <= s-i < N, else 0; col lane j slot s SHALL load i_b[s-j][j] when 0 <= s-j < N, else 0.
REQ-015 In RUN, o_doProcess SHALL be high; on every RUN edge each lane SHALL shift one slot toward slot 0, zero-filling slot 2N-2.
REQ-016 RUN SHALL last exactly 3N-2 cycles, counted by a counter cleared on entry; RUN -> DRAIN on the last count.
REQ-017 DRAIN SHALL last one cycle with o_doProcess low, capture i_c into o_result at its closing edge, and go to DONE.
REQ-018 DONE SHALL hold o_valid high and o_result stable until i_ready is high; DONE -> IDLE on the edge where i_ready is high.
REQ-019 o_valid SHALL first be high 3N cycles after the edge that accepted i_start (12 for N=4); earliest next acceptance is 1 cycle after the i_ready handshake.
REQ-020 Outside RUN, o_row and o_col SHALL be all zero and o_doProcess low.
REQ-021 o_result SHALL retain its last captured value after DONE until the next capture.
REQ-022 The counter SHALL be ceil(log2(3N-1)) bits and never wrap within RUN.

Reset
REQ-023 On i_arst high, at any time including mid-RUN: state IDLE, counter 0, lanes 0, o_doProcess 0, o_valid 0, o_result 0, o_ready 1 once released.
REQ-024 Reset release SHALL NOT resume an interrupted operation.

Structure
REQ-025 A shared package systolic_pkg SHALL hold the default N, the FSM state enum, the RUN-length constant 3N-2, and operand/accumulator width constants (8, 32).
REQ-026 One sub-module, systolic_skew_buffer (N lanes, parallel skewed load, shift-to-slot-0), SHALL be instantiated twice: rows and cols; the FSM, counter and capture stay in systolic_sequencer.

Verification
REQ-027 i_a = identity, i_b[r][c] = 4r+c+1, i_ready tied high -> o_valid 12 cycles after acceptance, o_result[r][c] = 4r+c+1, o_doProcess high exactly 10 cycles.
REQ-028 i_a = i_b = all 255 -> every o_result element = 260100; no overflow bits set above bit 17.
REQ-029 i_start pulsed in RUN cycle 3 with different operands -> ignored; result equals first operands' product; o_ready low throughout.
REQ-030 i_ready low for 5 cycles after o_valid rises -> o_valid and o_result stable all 5 cycles; IDLE and o_ready high 1 cycle after i_ready asserted.
REQ-031 i_arst pulsed in RUN cycle 5 -> o_doProcess, o_valid, lanes 0 immediately; new start after release yields correct product from clean accumulators.
REQ-032 Back-to-back: i_start held high, i_ready high -> second acceptance 1 cycle after first handshake; both results correct, with one low-o_doProcess DRAIN cycle between runs.
